// File: rtl/roi_shift_driver_pkg.sv
// Shared state encoding and default sizing for the ROI shift-chain driver.
package roi_shift_pkg;

  localparam int N_DEFAULT      = 256;
  localparam int SETTLE_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_LOAD,
    ST_SETTLE,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/roi_shift_driver_if.sv
// Parallel request/response bundle between a host and roi_shift_driver.
// Macro ROI_SHIFT_DRIVER_CHECK_EN adds exp_in / mismatch for on-chip comparison.
interface roi_shift_driver_if #(
  parameter int N = roi_shift_pkg::N_DEFAULT
);

  logic         start;
  logic [N-1:0] vec_in;
  logic         busy;
  logic         done;
  logic [N-1:0] vec_out;

`ifdef ROI_SHIFT_DRIVER_CHECK_EN
  logic [N-1:0] exp_in;
  logic         mismatch;

  modport master (output start, vec_in, exp_in,
                  input  busy, done, vec_out, mismatch);
  modport slave  (input  start, vec_in, exp_in,
                  output busy, done, vec_out, mismatch);
`else
  modport master (output start, vec_in,
                  input  busy, done, vec_out);
  modport slave  (input  start, vec_in,
                  output busy, done, vec_out);
`endif

endinterface

// File: rtl/roi_shift_driver_ser.sv
// N-bit shift register: parallel load, MSB serial out, LSB serial in, parallel read.
module roi_shift_ser
  import roi_shift_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         sin,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift) begin
      q_d = {q_q[N-2:0], sin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/roi_shift_driver.sv
// Drives one load/capture transaction through a serial ROI chain harness.
// Macro ROI_SHIFT_DRIVER_CHECK_EN adds exp_in latching and a registered mismatch flag.
module roi_shift_driver
  import roi_shift_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  roi_shift_driver_if.slave bus,
  output logic              di,
  output logic              stb,
  input  logic              do_ser
);

  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(SETTLE + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          di_q, di_d;
  logic          stb_q, stb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  vec_out_q, vec_out_d;
  logic          ser_load;
  logic          ser_shift;
  logic [N-1:0]  ser_q;

  // One register serves both directions: MSB feeds di, do_ser enters at the LSB.
  roi_shift_ser #(.N(N)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ser_load),
    .load_val (bus.vec_in),
    .shift    (ser_shift),
    .sin      (do_ser),
    .q        (ser_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    vec_out_d = vec_out_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    di_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ser_load = 1'b1;
          cnt_d    = '0;
          di_d     = bus.vec_in[N-1];
          state_d  = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        ser_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
          di_d  = ser_q[N-2];
        end
      end
      ST_LOAD: begin
        scnt_d  = '0;
        state_d = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (scnt_q == SET_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_CAPTURE: begin
        cnt_d   = '0;
        state_d = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        ser_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          vec_out_d = {ser_q[N-2:0], do_ser};
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    stb_d  = (state_d == ST_LOAD) || (state_d == ST_CAPTURE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      scnt_q    <= '0;
      di_q      <= 1'b0;
      stb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vec_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      di_q      <= di_d;
      stb_q     <= stb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vec_out_q <= vec_out_d;
    end
  end

  assign di          = di_q;
  assign stb         = stb_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.vec_out = vec_out_q;

`ifdef ROI_SHIFT_DRIVER_CHECK_EN
  logic [N-1:0] exp_q, exp_d;
  logic         mismatch_q, mismatch_d;

  // Compare against the full response the same edge it becomes visible on vec_out.
  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    if (state_q == ST_IDLE && bus.start) begin
      exp_d      = bus.exp_in;
      mismatch_d = 1'b0;
    end else if (state_q == ST_SHIFT_OUT && state_d == ST_DONE) begin
      mismatch_d = (vec_out_d != exp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign bus.mismatch = mismatch_q;
`endif

endmodule

// File: doc/roi_shift_driver.md
ROI_SHIFT_DRIVER -- requirements
Module: roi_shift_driver

Interface
REQ-001 Parameter N, default 256: serial chain length, equal to the harness DIN_N and DOUT_N; legal range 8..1024.
REQ-002 Parameter SETTLE, default 4: idle cycles between the load strobe and the capture strobe; legal range 0..255.
REQ-003 clk  input  1  sole clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request one load/capture transaction; sampled only in IDLE.
REQ-006 vec_in  input  N  parallel stimulus vector, latched on an accepted start.
REQ-007 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-008 done  output  1  one-cycle pulse; vec_out is valid from this cycle on.
REQ-009 vec_out  output  N  captured response vector; holds until the next done.
REQ-010 di  output  1  serial data to the harness; registered.
REQ-011 stb  output  1  harness strobe; registered.
REQ-012 do_ser  input  1  serial data from the harness (harness port do).

Function
REQ-013 States: IDLE, SHIFT_IN, LOAD, SETTLE, CAPTURE, SHIFT_OUT, DONE.
REQ-014 IDLE: when start=1, latch vec_in into the shift register, clear the bit counter and move to SHIFT_IN.
REQ-015 SHIFT_IN lasts exactly N cycles; di carries vec_in[N-1] first and vec_in[0] last (MSB-first).
REQ-016 After SHIFT_IN, bit i of the latched vector sits at harness din_shr[i].
REQ-017 LOAD lasts 1 cycle with stb=1, then goes to SETTLE, or to CAPTURE when SETTLE=0.
REQ-018 SETTLE lasts exactly SETTLE cycles with stb=0, then goes to CAPTURE.
REQ-019 CAPTURE lasts 1 cycle with stb=1, then goes to SHIFT_OUT.
REQ-020 SHIFT_OUT lasts exactly N cycles with stb=0.
REQ-021 In SHIFT_OUT, sample do_ser at each clock edge; the first sample goes to vec_out[N-1] and the Nth sample to vec_out[0].
REQ-022 The first SHIFT_OUT sample is taken at the end of the cycle immediately after CAPTURE; no gap cycle is inserted.
REQ-023 vec_out updates once, at the DONE transition, from an internal capture register; it never shows partial data.
REQ-024 DONE lasts 1 cycle with done=1, then returns to IDLE.
REQ-025 di=0 in every state except SHIFT_IN.
REQ-026 stb is high only in LOAD and CAPTURE.
REQ-027 start is ignored in every state except IDLE, including DONE.
REQ-028 Total transaction length from start acceptance to done is 2N+SETTLE+3 cycles.
REQ-029 The bit counter is sized $clog2(N+1) and never wraps within a state.

Reset
REQ-030 rst_n low at any time, including mid-SHIFT_IN or mid-SHIFT_OUT, immediately forces IDLE, di=0, stb=0, busy=0, done=0, vec_out=0, and clears the counters.
REQ-031 After reset the harness chain content is undefined; the first transaction after reset is nevertheless fully valid, because SHIFT_IN overwrites all N bits.

Configuration
REQ-032 With macro ROI_SHIFT_DRIVER_CHECK_EN defined, the block adds input exp_in[N-1:0], latched with vec_in, and output mismatch.
REQ-033 mismatch is registered, asserts in the DONE cycle when the captured response differs from exp_in, holds until the next accepted start, and resets to 0.
REQ-034 With ROI_SHIFT_DRIVER_CHECK_EN undefined, neither port exists and the block holds no expected-vector storage.

Structure
REQ-035 A shared package roi_shift_pkg holds the state enum and the default constants for N and SETTLE.
REQ-036 One sub-module, roi_shift_ser, is natural: an N-bit parallel-load/serial-out and serial-in/parallel-out register with shift and load enables.

Verification
REQ-037 The bench connects the driver to a behavioural harness model whose ROI is an N-bit register with dout=din.
REQ-038 Scenario: N=256, SETTLE=4, vec_in=256'h0123...CDEF repeated -> done at cycle 2N+7 after start; vec_out equals vec_in.
REQ-039 Scenario: vec_in=1<<255, then 1<<0 -> vec_out exactly matches each vector (checks bit order and end bits).
REQ-040 Scenario: SETTLE=0 -> stb is high on two consecutive cycles; done at cycle 2N+3; data is correct.
REQ-041 Scenario: start is held high continuously -> transactions run back-to-back with exactly one IDLE cycle between DONE and the next SHIFT_IN; start during busy is ignored.
REQ-042 Scenario: rst_n is pulsed low at SHIFT_OUT bit 100 -> outputs clear in the same cycle; the next transaction returns the correct vector.
REQ-043 Scenario (CHECK_EN): exp_in differs from vec_in in bit 17 -> mismatch=1 at done; with equal vectors, mismatch=0.
